// File: rtl/bus_reg_interface_if.sv
// Signal bundle between the host byte bus, the bridge and the register block.
// bus_data_oe is present only when BUS_DATA_OE_EN is defined.
interface bus_reg_interface_if #(
    parameter int REG_BITS = 4
);
    logic                bus_sel_n;
    logic                bus_rd_nwr;
    logic [REG_BITS-1:0] bus_reg_num;
    logic                bus_bytesel;
    logic [7:0]          bus_wdata;
    logic [7:0]          bus_rdata;
`ifdef BUS_DATA_OE_EN
    logic                bus_data_oe;
`endif
    logic                write_strobe;
    logic                rd_strobe;
    logic [REG_BITS-1:0] reg_num;
    logic [15:0]         reg_wdata;
    logic [15:0]         reg_rdata;

    modport slave (
        input  bus_sel_n, bus_rd_nwr, bus_reg_num, bus_bytesel, bus_wdata, reg_rdata,
`ifdef BUS_DATA_OE_EN
        output bus_data_oe,
`endif
        output bus_rdata, write_strobe, rd_strobe, reg_num, reg_wdata
    );

    modport master (
        output bus_sel_n, bus_rd_nwr, bus_reg_num, bus_bytesel, bus_wdata, reg_rdata,
`ifdef BUS_DATA_OE_EN
        input  bus_data_oe,
`endif
        input  bus_rdata, write_strobe, rd_strobe, reg_num, reg_wdata
    );
endinterface

// File: rtl/bus_reg_interface.sv
// Host 8-bit bus to 16-bit register-word bridge: input synchronisers, even/odd write pairing, latched reads.
// Define BUS_DATA_OE_EN to add the bus_data_oe transceiver-direction output.
//
// state   | meaning
// IDLE    | waiting for an accepted select fall
// WR_HOLD | write cycle open, acts on select rise
// RD_REQ  | read decode: issue rd_strobe or serve the cached odd byte
// RD_WAIT | counting read latency before latching reg_rdata
// RD_HOLD | read byte presented, waiting for select rise
module bus_reg_interface #(
    parameter int SYNC_STAGES = 2,
    parameter int REG_BITS    = 4,
    parameter int RD_LATENCY  = 1
) (
    input logic                clk,
    input logic                rst,
    bus_reg_interface_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WR_HOLD, RD_REQ, RD_WAIT, RD_HOLD} state_t;

    localparam int         SW  = REG_BITS + 11;
    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t state, state_nx;

    logic [SW-1:0]          sync_q [SYNC_STAGES];
    logic [SW-1:0]          sync_in;
    logic [SW-1:0]          sync_out;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   sel_s, rd_nwr_s, byte_s;
    logic [REG_BITS-1:0]    reg_s;
    logic [7:0]             data_s;

    logic                sel_prev, armed, start, hit;
    logic [REG_BITS-1:0] cur_reg, even_reg, rd_reg, reg_num;
    logic                cur_byte, even_valid, rd_valid;
    logic [7:0]          even_data, bus_rdata;
    logic [15:0]         rd_word, reg_wdata;
    logic [2:0]          lat_cnt;
    logic                write_strobe, rd_strobe;
    logic                do_even, do_odd, do_rd_req, do_fast, do_latch;

    // Select is carried active-high so the all-zero reset value means "deasserted".
    assign sync_in  = {~bus.bus_sel_n, bus.bus_rd_nwr, bus.bus_reg_num, bus.bus_bytesel, bus.bus_wdata};
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign sel_s    = sync_out[SW-1];
    assign rd_nwr_s = sync_out[SW-2];
    assign reg_s    = sync_out[SW-3 -: REG_BITS];
    assign byte_s   = sync_out[8];
    assign data_s   = sync_out[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prime_q <= '0;
        end else begin
            sync_q[0] <= sync_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign start = armed & sel_s & ~sel_prev;
    assign hit   = rd_valid && (rd_reg == cur_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_even   = 1'b0;
        do_odd    = 1'b0;
        do_rd_req = 1'b0;
        do_fast   = 1'b0;
        do_latch  = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = rd_nwr_s ? RD_REQ : WR_HOLD;
            WR_HOLD: if (!sel_s) begin
                         state_nx = IDLE;
                         do_odd   = cur_byte;
                         do_even  = ~cur_byte;
                     end
            RD_REQ:  if (cur_byte && hit) begin
                         do_fast  = 1'b1;
                         state_nx = sel_s ? RD_HOLD : IDLE;
                     end else begin
                         do_rd_req = 1'b1;
                         state_nx  = RD_WAIT;
                     end
            // Latch always completes, even if select already rose, so rd_word stays coherent.
            RD_WAIT: if (lat_cnt == 3'd0) begin
                         do_latch = 1'b1;
                         state_nx = sel_s ? RD_HOLD : IDLE;
                     end
            RD_HOLD: if (!sel_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_prev     <= 1'b0;
            armed        <= 1'b0;
            cur_reg      <= '0;
            cur_byte     <= 1'b0;
            lat_cnt      <= '0;
            even_valid   <= 1'b0;
            even_reg     <= '0;
            even_data    <= '0;
            rd_valid     <= 1'b0;
            rd_reg       <= '0;
            rd_word      <= '0;
            write_strobe <= 1'b0;
            rd_strobe    <= 1'b0;
            reg_num      <= '0;
            reg_wdata    <= '0;
            bus_rdata    <= '0;
        end else begin
            sel_prev     <= sel_s;
            write_strobe <= 1'b0;
            rd_strobe    <= 1'b0;
            // Arm only once the synchroniser holds real samples, so a select held low through reset is ignored.
            if (prime_q[SYNC_STAGES-1] && !sel_s) armed <= 1'b1;
            if (state == IDLE && start) begin
                cur_reg  <= reg_s;
                cur_byte <= byte_s;
            end
            if (do_rd_req)                            lat_cnt <= LAT;
            else if (state == RD_WAIT && lat_cnt != 0) lat_cnt <= lat_cnt - 3'd1;
            if (do_even) begin
                even_reg   <= cur_reg;
                even_data  <= data_s;
                even_valid <= 1'b1;
            end
            if (do_odd) begin
                write_strobe <= 1'b1;
                reg_num      <= cur_reg;
                reg_wdata    <= (even_valid && even_reg == cur_reg) ? {even_data, data_s} : {8'h00, data_s};
                even_valid   <= 1'b0;
            end
            if ((do_even || do_odd) && cur_reg == rd_reg) rd_valid <= 1'b0;
            if (do_rd_req) begin
                rd_strobe <= 1'b1;
                reg_num   <= cur_reg;
            end
            if (do_fast) begin
                bus_rdata <= rd_word[7:0];
                rd_valid  <= 1'b0;
            end
            if (do_latch) begin
                rd_word   <= bus.reg_rdata;
                rd_reg    <= cur_reg;
                rd_valid  <= ~cur_byte;
                bus_rdata <= cur_byte ? bus.reg_rdata[7:0] : bus.reg_rdata[15:8];
            end
        end
    end

`ifdef BUS_DATA_OE_EN
    logic data_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     data_oe <= 1'b0;
        else if (state == IDLE && start && rd_nwr_s) data_oe <= 1'b1;
        else if (!sel_s)                             data_oe <= 1'b0;
    end

    assign bus.bus_data_oe = data_oe;
`endif

    assign bus.write_strobe = write_strobe;
    assign bus.rd_strobe    = rd_strobe;
    assign bus.reg_num      = reg_num;
    assign bus.reg_wdata    = reg_wdata;
    assign bus.bus_rdata    = bus_rdata;
endmodule
